cpu_run_ctrl: RTL

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Run/pause/single-step controller for a small soft processor. It holds the
// processor in reset after system reset, then gates its clock enable from a
// run switch and a debounced step button. It also snapshots a result register
// whenever the processor stops, and counts enabled cycles.
//
// Ports
//   clk          system clock; all logic on the rising edge
//   reset        synchronous, active-high reset
//   sw_run       asynchronous run switch level (1 = run, 0 = pause)
//   btn_step     asynchronous, bouncy single-step button
//   halt_in      processor halt-retired indication, synchronous to clk
//   reg_rdata    register-file read data (1-cycle read latency)
//   cpu_ce       processor clock enable
//   cpu_rst      processor synchronous reset
//   reg_raddr    register-file read address (fixed at RESULT_REG)
//   snap         captured result-register value
//   snap_valid   snap holds the value for the current pause/halt
//   cycle_count  saturating count of cycles with cpu_ce = 1
//   state_out    current FSM state encoding
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned RST_HOLD   = 4,
  parameter logic [3:0]  RESULT_REG = 4'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sw_run,
  input  logic        btn_step,
  input  logic        halt_in,
  input  logic [31:0] reg_rdata,
  output logic        cpu_ce,
  output logic        cpu_rst,
  output logic [3:0]  reg_raddr,
  output logic [31:0] snap,
  output logic        snap_valid,
  output logic [31:0] cycle_count,
  output logic [2:0]  state_out
);

  // The debounce counter only has to reach DEB_CYCLES-1, the INIT hold
  // counter only RST_HOLD-1.
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    PAUSE  = 3'd1,
    RUN    = 3'd2,
    STEP   = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_n;
  logic [HW-1:0]   hold_cnt;

  logic            sw_s1;
  logic            sw_s2;
  logic            btn_s1;
  logic            btn_s2;
  logic [1:0]      sync_fill;
  logic            armed;

  logic            deb_level;
  logic [DW-1:0]   deb_cnt;
  logic            step_pulse;

  logic            cap_pend;
  logic            enter_go;
  logic            enter_stop;

  // Two-flop synchronizers for the asynchronous switch and button.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1  <= 1'b0;
      sw_s2  <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      sw_s1  <= sw_run;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_step;
      btn_s2 <= btn_s1;
    end
  end

  // The synchronizer flops are cleared by reset, so btn_s2 only reflects the
  // real button two cycles later. Step pulses stay disarmed until the button
  // has actually been seen released, so a press held through reset cannot
  // turn into a step.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_fill <= 2'd0;
      armed     <= 1'b0;
    end else begin
      if (sync_fill != 2'd2) begin
        sync_fill <= sync_fill + 2'd1;
      end
      if (sync_fill == 2'd2 && !btn_s2) begin
        armed <= 1'b1;
      end
    end
  end

  // The debounced level follows the synchronized button only after it has
  // disagreed for DEB_CYCLES cycles in a row. Any agreement restarts the
  // count. A 0->1 change of the level emits a single-cycle step pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_level  <= 1'b0;
      deb_cnt    <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (btn_s2 != deb_level) begin
        if (deb_cnt == DEB_LAST) begin
          deb_level  <= btn_s2;
          deb_cnt    <= '0;
          step_pulse <= btn_s2 & armed;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // State register plus the INIT hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= INIT;
      hold_cnt <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == INIT && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + HW'(1);
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  // Next-state logic and output decode. cpu_ce and cpu_rst come straight
  // from the state register, so they only change right after a clock edge.
  // Run beats step in PAUSE, and halt beats pause in RUN.
  always_comb begin
    state_n = state_q;
    cpu_ce  = 1'b0;
    cpu_rst = 1'b0;
    case (state_q)
      INIT: begin
        cpu_rst = 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_n = PAUSE;
        end
      end
      PAUSE: begin
        if (sw_s2) begin
          state_n = RUN;
        end else if (step_pulse) begin
          state_n = STEP;
        end
      end
      RUN: begin
        cpu_ce = 1'b1;
        if (halt_in) begin
          state_n = HALTED;
        end else if (!sw_s2) begin
          state_n = PAUSE;
        end
      end
      STEP: begin
        cpu_ce = 1'b1;
        if (halt_in) begin
          state_n = HALTED;
        end else begin
          state_n = PAUSE;
        end
      end
      HALTED: begin
        state_n = HALTED;
      end
      default: begin
        state_n = INIT;
        cpu_rst = 1'b1;
      end
    endcase
  end

  assign enter_go   = (state_n == RUN || state_n == STEP) && (state_n != state_q);
  assign enter_stop = (state_n == PAUSE || state_n == HALTED) &&
                      (state_q == RUN || state_q == STEP);

  // The snapshot is taken one cycle after the processor stops. That gives
  // the last instruction's write-back time to settle and covers the
  // register file's read latency. Starting to run or step again
  // invalidates the snapshot and cancels any capture still pending. The
  // old value is left in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap       <= 32'd0;
      snap_valid <= 1'b0;
      cap_pend   <= 1'b0;
    end else if (enter_go) begin
      snap_valid <= 1'b0;
      cap_pend   <= 1'b0;
    end else begin
      if (cap_pend) begin
        snap       <= reg_rdata;
        snap_valid <= 1'b1;
      end
      cap_pend <= enter_stop;
    end
  end

  // Enabled-cycle counter. It saturates instead of wrapping, and only reset
  // clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= 32'd0;
    end else if (cpu_ce && cycle_count != 32'hFFFF_FFFF) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  assign reg_raddr = RESULT_REG;
  assign state_out = state_q;

endmodule
